// File: rtl/rv32i_pkg.sv
// RV32I front-end constants: instruction types, opcodes, control-word
// layout, the BUBBLE word, branch fun3 codes and field helpers.
package rv32i_pkg;

  localparam int CW_W = 23;

  localparam logic [3:0] T_LOAD   = 4'd0;
  localparam logic [3:0] T_IMM    = 4'd1;
  localparam logic [3:0] T_STORE  = 4'd2;
  localparam logic [3:0] T_REG    = 4'd3;
  localparam logic [3:0] T_LUI    = 4'd4;
  localparam logic [3:0] T_AUIPC  = 4'd5;
  localparam logic [3:0] T_BRANCH = 4'd6;
  localparam logic [3:0] T_JALR   = 4'd7;
  localparam logic [3:0] T_JAL    = 4'd8;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int CW_TYPE = 0;
  localparam int CW_FUN3 = 4;
  localparam int CW_FUN7 = 7;
  localparam int CW_RD   = 8;
  localparam int CW_RS1  = 13;
  localparam int CW_RS2  = 18;

  // never-taken branch with no register fields
  localparam logic [CW_W-1:0] BUBBLE =
    {15'd0, 1'b0, 3'b010, T_BRANCH};

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic [CW_W-1:0] cw_pack(
    input logic [4:0] rs2,
    input logic [4:0] rs1,
    input logic [4:0] rd,
    input logic       f7,
    input logic [2:0] f3,
    input logic [3:0] t
  );
    logic [CW_W-1:0] c;
    c = '0;
    c[CW_TYPE +: 4] = t;
    c[CW_FUN3 +: 3] = f3;
    c[CW_FUN7]      = f7;
    c[CW_RD +: 5]   = rd;
    c[CW_RS1 +: 5]  = rs1;
    c[CW_RS2 +: 5]  = rs2;
    return c;
  endfunction

  function automatic logic [3:0] cw_type(
    input logic [CW_W-1:0] c
  );
    return c[CW_TYPE +: 4];
  endfunction

  function automatic logic [2:0] cw_fun3(
    input logic [CW_W-1:0] c
  );
    return c[CW_FUN3 +: 3];
  endfunction

  function automatic logic [4:0] cw_rd(
    input logic [CW_W-1:0] c
  );
    return c[CW_RD +: 5];
  endfunction

  function automatic logic [4:0] cw_rs1(
    input logic [CW_W-1:0] c
  );
    return c[CW_RS1 +: 5];
  endfunction

  function automatic logic [4:0] cw_rs2(
    input logic [CW_W-1:0] c
  );
    return c[CW_RS2 +: 5];
  endfunction

  function automatic logic writes_rd(
    input logic [3:0] t
  );
    return (t != T_STORE) && (t != T_BRANCH);
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: instr -> {cword, imm, illegal}.
// Ports: instr in, cword/imm/illegal out; unknown opcodes give BUBBLE.
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [CW_W-1:0] cword,
  output logic [31:0]     imm,
  output logic            illegal
);

  logic [6:0]  op;
  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] imm_u, imm_j, sel;
  logic [3:0]  itype;
  logic [4:0]  rd, rs1, rs2;
  logic        f7;

  assign op    = instr[6:0];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25],
                  instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  always_comb begin
    itype   = T_IMM;
    sel     = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_LOAD): begin
        itype = T_LOAD;
        sel   = imm_i;
      end
      (op == OP_IMM): begin
        itype = T_IMM;
        sel   = imm_i;
      end
      (op == OP_STORE): begin
        itype = T_STORE;
        sel   = imm_s;
      end
      (op == OP_REG): begin
        itype = T_REG;
      end
      (op == OP_LUI): begin
        itype = T_LUI;
        sel   = imm_u;
      end
      (op == OP_AUIPC): begin
        itype = T_AUIPC;
        sel   = imm_u;
      end
      (op == OP_BRANCH): begin
        itype = T_BRANCH;
        sel   = imm_b;
      end
      (op == OP_JALR): begin
        itype = T_JALR;
        sel   = imm_i;
      end
      (op == OP_JAL): begin
        itype = T_JAL;
        sel   = imm_j;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign f7 = instr[30] &
    ((itype == T_IMM) || (itype == T_REG));

  assign rs1 = ((itype == T_LUI) ||
                (itype == T_AUIPC) ||
                (itype == T_JAL)) ? 5'd0 : instr[19:15];

  assign rs2 = ((itype == T_REG) ||
                (itype == T_STORE) ||
                (itype == T_BRANCH)) ? instr[24:20] : 5'd0;

  assign rd = ((itype == T_STORE) ||
               (itype == T_BRANCH)) ? 5'd0 : instr[11:7];

  assign cword = illegal ? BUBBLE :
    cw_pack(rs2, rs1, rd, f7, instr[14:12], itype);
  assign imm = illegal ? 32'd0 : sel;

endmodule

// File: rtl/fetch_decode_ctrl.sv
// RV32I front end: PC, IF/ID, decode, ID..WB control pipeline, interlocks.
// Ports: imem fetch, cwordID..WB/pc/immEX/immMEM to datapath, flags/r_for_pc in.
module fetch_decode_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [31:0]     imem_addr,
  input  logic [31:0]     imem_data,
  output logic [CW_W-1:0] cwordID,
  output logic [CW_W-1:0] cwordEX,
  output logic [CW_W-1:0] cwordMEM,
  output logic [CW_W-1:0] cwordWB,
  output logic [31:0]     pc,
  output logic [31:0]     immEX,
  output logic [31:0]     immMEM,
  input  logic [31:0]     r_for_pc,
  input  logic [3:0]      funit_ZCNVFlags,
  output logic            ill_seen
);

  logic [31:0]     pc_if, id_instr, id_pc;
  logic            id_valid;
  logic [CW_W-1:0] dec_cw;
  logic [31:0]     dec_imm, imm_id, pc_id;
  logic            dec_ill;
  logic            fz, fc, fn, fv;
  logic            br_take, redirect;
  logic            load_use, jalr_hold, stall;
  logic [31:0]     target;
  logic [3:0]      t_ex, t_mem;
  logic [4:0]      rd_ex, rd_mem;
  logic [4:0]      rs1_id, rs2_id;

  rv32i_decoder u_dec (
    .instr   (id_instr),
    .cword   (dec_cw),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign imem_addr = pc_if;
  assign cwordID   = id_valid ? dec_cw : BUBBLE;
  assign imm_id    = id_valid ? dec_imm : 32'd0;
  assign pc_id     = id_valid ? id_pc : 32'd0;

  assign {fz, fc, fn, fv} = funit_ZCNVFlags;

  assign t_ex   = cw_type(cwordEX);
  assign t_mem  = cw_type(cwordMEM);
  assign rd_ex  = cw_rd(cwordEX);
  assign rd_mem = cw_rd(cwordMEM);
  assign rs1_id = cw_rs1(cwordID);
  assign rs2_id = cw_rs2(cwordID);

  always_comb begin
    br_take = 1'b0;
    unique case (cw_fun3(cwordEX))
      F3_BEQ:  br_take = fz;
      F3_BNE:  br_take = !fz;
      F3_BLT:  br_take = fn ^ fv;
      F3_BGE:  br_take = !(fn ^ fv);
      F3_BLTU: br_take = !fc;
      F3_BGEU: br_take = fc;
      default: br_take = 1'b0;
    endcase
  end

  assign redirect = ((t_ex == T_BRANCH) & br_take) |
                    (t_ex == T_JAL) | (t_ex == T_JALR);

  assign target = (t_ex == T_JALR) ?
    ((r_for_pc + immEX) & ~32'h1) : (pc + immEX);

  // rd of x0 never matches: unused rs fields decode to 0
  assign load_use = id_valid & (t_ex == T_LOAD) &
    (rd_ex != 5'd0) &
    ((rd_ex == rs1_id) | (rd_ex == rs2_id));

  // r_for_pc is unforwarded; wait until the producer is in WB
  assign jalr_hold = id_valid &
    (cw_type(cwordID) == T_JALR) & (rs1_id != 5'd0) &
    ((writes_rd(t_ex) & (rd_ex == rs1_id)) |
     (writes_rd(t_mem) & (rd_mem == rs1_id)));

  assign stall = load_use | jalr_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_if    <= RESET_PC;
      id_instr <= '0;
      id_pc    <= '0;
      id_valid <= 1'b0;
      cwordEX  <= BUBBLE;
      cwordMEM <= BUBBLE;
      cwordWB  <= BUBBLE;
      immEX    <= '0;
      immMEM   <= '0;
      pc       <= '0;
      ill_seen <= 1'b0;
    end else begin
      cwordMEM <= cwordEX;
      immMEM   <= immEX;
      cwordWB  <= cwordMEM;
      if (redirect) begin
        pc_if    <= target;
        id_valid <= 1'b0;
        cwordEX  <= BUBBLE;
        immEX    <= '0;
        pc       <= '0;
      end else if (stall) begin
        cwordEX <= BUBBLE;
        immEX   <= '0;
        pc      <= '0;
      end else begin
        pc_if    <= pc_if + 32'd4;
        id_instr <= imem_data;
        id_pc    <= pc_if;
        id_valid <= 1'b1;
        cwordEX  <= cwordID;
        immEX    <= imm_id;
        pc       <= pc_id;
      end
      if (id_valid & dec_ill)
        ill_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: directed program plus random programs
// compared each cycle against an instruction-level pipeline model.
module tb_fetch_decode_ctrl;

  localparam logic [22:0] BUB = 23'h000026;

  typedef struct packed {
    logic [3:0]  typ;
    logic [2:0]  fun3;
    logic        fun7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_data;
  logic [22:0] cwordID, cwordEX, cwordMEM, cwordWB;
  logic [31:0] pc, immEX, immMEM, r_for_pc;
  logic [3:0]  funit_ZCNVFlags;
  logic        ill_seen;

  logic [31:0] mem [64];

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pcif, m_idi, m_idpc;
  logic        m_idv, m_ill;
  rec_t        m_ex, m_mem, m_wb;

  fetch_decode_ctrl #(.RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .cwordID         (cwordID),
    .cwordEX         (cwordEX),
    .cwordMEM        (cwordMEM),
    .cwordWB         (cwordWB),
    .pc              (pc),
    .immEX           (immEX),
    .immMEM          (immMEM),
    .r_for_pc        (r_for_pc),
    .funit_ZCNVFlags (funit_ZCNVFlags),
    .ill_seen        (ill_seen)
  );

  always #5 clk = ~clk;

  always_comb imem_data = mem[imem_addr[7:2]];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic rec_t bub();
    rec_t r;
    r = '0;
    r.typ  = 4'd6;
    r.fun3 = 3'b010;
    return r;
  endfunction

  function automatic logic [22:0] pack(input rec_t r);
    return {r.rs2, r.rs1, r.rd, r.fun7, r.fun3, r.typ};
  endfunction

  function automatic rec_t mdecode(input logic [31:0] w,
                                   input logic [31:0] at);
    rec_t r;
    logic signed [31:0] sw;
    logic [31:0] s20, s25, s31;
    sw  = w;
    s20 = sw >>> 20;
    s25 = sw >>> 25;
    s31 = sw >>> 31;
    r = '0;
    r.pc   = at;
    r.fun3 = w[14:12];
    r.rd   = w[11:7];
    r.rs1  = w[19:15];
    r.rs2  = w[24:20];
    case (w[6:0])
      7'h03: begin r.typ = 0; r.imm = s20; end
      7'h13: begin r.typ = 1; r.imm = s20; end
      7'h23: begin
        r.typ = 2;
        r.imm = (s25 << 5) | 32'(w[11:7]);
      end
      7'h33: begin r.typ = 3; r.imm = 0; end
      7'h37: begin r.typ = 4; r.imm = w & 32'hFFFF_F000; end
      7'h17: begin r.typ = 5; r.imm = w & 32'hFFFF_F000; end
      7'h63: begin
        r.typ = 6;
        r.imm = (s31 << 12) | (32'(w[7]) << 11) |
                (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      end
      7'h67: begin r.typ = 7; r.imm = s20; end
      7'h6f: begin
        r.typ = 8;
        r.imm = (s31 << 20) | (32'(w[19:12]) << 12) |
                (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      default: begin
        r = bub();
        r.pc  = at;
        r.ill = 1'b1;
        return r;
      end
    endcase
    if (r.typ == 4 || r.typ == 5 || r.typ == 8) r.rs1 = 0;
    if (!(r.typ == 2 || r.typ == 3 || r.typ == 6)) r.rs2 = 0;
    if (r.typ == 2 || r.typ == 6) r.rd = 0;
    r.fun7 = (r.typ == 1 || r.typ == 3) ? w[30] : 1'b0;
    return r;
  endfunction

  function automatic bit writes(input rec_t r);
    return r.typ != 2 && r.typ != 6;
  endfunction

  task automatic model_reset();
    m_pcif = 32'h0;
    m_idv  = 1'b0;
    m_idi  = '0;
    m_idpc = '0;
    m_ex   = bub();
    m_mem  = bub();
    m_wb   = bub();
    m_ill  = 1'b0;
  endtask

  task automatic model_step();
    rec_t id;
    bit z, c, n, v, taken, jump, hold;
    logic [31:0] dest;
    id = m_idv ? mdecode(m_idi, m_idpc) : bub();
    if (m_idv && id.ill) m_ill = 1'b1;
    {z, c, n, v} = funit_ZCNVFlags;
    case (m_ex.fun3)
      3'd0:    taken = z;
      3'd1:    taken = !z;
      3'd4:    taken = (n != v);
      3'd5:    taken = (n == v);
      3'd6:    taken = !c;
      3'd7:    taken = c;
      default: taken = 0;
    endcase
    jump = m_ex.typ == 8 || m_ex.typ == 7 ||
           (m_ex.typ == 6 && taken);
    if (m_ex.typ == 7)
      dest = (r_for_pc + m_ex.imm) & ~32'h1;
    else
      dest = m_ex.pc + m_ex.imm;
    hold = m_idv && m_ex.typ == 0 && m_ex.rd != 0 &&
           (m_ex.rd == id.rs1 || m_ex.rd == id.rs2);
    if (m_idv && id.typ == 7 && id.rs1 != 0 &&
        ((writes(m_ex) && m_ex.rd == id.rs1) ||
         (writes(m_mem) && m_mem.rd == id.rs1)))
      hold = 1;
    m_wb  = m_mem;
    m_mem = m_ex;
    if (jump) begin
      m_ex   = bub();
      m_pcif = dest;
      m_idv  = 0;
    end else if (hold) begin
      m_ex = bub();
    end else begin
      m_ex   = id;
      m_idi  = mem[m_pcif[7:2]];
      m_idpc = m_pcif;
      m_idv  = 1;
      m_pcif = m_pcif + 4;
    end
  endtask

  task automatic compare_model();
    logic [22:0] cid;
    cid = m_idv ? pack(mdecode(m_idi, m_idpc)) : BUB;
    check("imem_addr", imem_addr, m_pcif);
    check("cwordID", 32'(cwordID), 32'(cid));
    check("cwordEX", 32'(cwordEX), 32'(pack(m_ex)));
    check("cwordMEM", 32'(cwordMEM), 32'(pack(m_mem)));
    check("cwordWB", 32'(cwordWB), 32'(pack(m_wb)));
    check("pc", pc, m_ex.pc);
    check("immEX", immEX, m_ex.imm);
    check("immMEM", immMEM, m_mem.imm);
    check("ill_seen", 32'(ill_seen), 32'(m_ill));
  endtask

  task automatic dir_checks(input int k);
    case (k)
      0: begin
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wb", 32'(cwordWB), 32'(BUB));
        check("rst_immmem", immMEM, 32'h0);
        check("rst_pc", pc, 32'h0);
      end
      2: begin
        check("addi_cw", 32'(cwordEX), 32'h101);
        check("addi_imm", immEX, 32'd5);
        check("addi_pc", pc, 32'd0);
      end
      3: check("lw_cw", 32'(cwordEX), 32'h2220);
      4: begin
        check("lu_hold", imem_addr, 32'd12);
        check("lu_bub", 32'(cwordEX), 32'(BUB));
      end
      5: check("add_cw", 32'(cwordEX), 32'h84303);
      6: begin
        check("ill_id", 32'(cwordID), 32'(BUB));
        check("ill_pre", 32'(ill_seen), 32'd0);
      end
      7: begin
        check("beq_tgt", imem_addr, 32'd28);
        check("beq_bub", 32'(cwordEX), 32'(BUB));
        check("ill_set", 32'(ill_seen), 32'd1);
      end
      10: check("jalr_st1", imem_addr, 32'd36);
      11: check("jalr_st2", imem_addr, 32'd36);
      13: check("jalr_tgt", imem_addr, 32'd32);
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic load_directed();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0000_A103;
    mem[2] = 32'h0021_01B3;
    mem[3] = 32'h0000_0863;
    mem[4] = 32'hFFFF_FFFF;
    mem[7] = 32'h0010_0293;
    mem[8] = 32'h0002_8067;
  endtask

  task automatic directed(input int stop, input bit mid);
    load_directed();
    funit_ZCNVFlags = 4'b1000;
    r_for_pc = 32'd33;
    do_reset();
    for (int k = 0; k <= stop; k++) begin
      @(negedge clk);
      compare_model();
      dir_checks(k);
      if (!(mid && k == stop)) model_step();
    end
    if (mid) begin
      #2 rst = 1'b0;
      #1;
      check("ar_addr", imem_addr, 32'h0);
      check("ar_id", 32'(cwordID), 32'(BUB));
      check("ar_ex", 32'(cwordEX), 32'(BUB));
      check("ar_mem", 32'(cwordMEM), 32'(BUB));
      check("ar_wb", 32'(cwordWB), 32'(BUB));
      check("ar_ill", 32'(ill_seen), 32'd0);
      model_reset();
    end
  endtask

  function automatic logic [31:0] gen_instr();
    int kind, o;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] i12;
    logic [2:0]  f3;
    logic [12:0] b;
    logic [20:0] j;
    kind = $urandom_range(0, 19);
    rd   = 5'($urandom_range(0, 3));
    rs1  = 5'($urandom_range(0, 3));
    rs2  = 5'($urandom_range(0, 3));
    i12  = 12'($urandom);
    f3   = 3'($urandom);
    o    = int'($urandom_range(0, 8)) - 4;
    b    = 13'(o * 4);
    j    = 21'(o * 4);
    case (kind)
      0, 1, 2: return {i12, rs1, f3, rd, 7'h03};
      3, 4, 5: return {i12, rs1, f3, rd, 7'h13};
      6: return {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23};
      7, 8, 9:
        return {1'b0, 1'($urandom), 5'b0, rs2, rs1, f3,
                rd, 7'h33};
      10: return {20'($urandom), rd, 7'h37};
      11: return {20'($urandom), rd, 7'h17};
      12, 13, 14:
        return {b[12], b[10:5], rs2, rs1, f3, b[4:1],
                b[11], 7'h63};
      15, 16:
        return {12'($urandom_range(0, 15)), rs1, 3'b0,
                rd, 7'h67};
      17:
        return {j[20], j[10:1], j[11], j[19:12], rd,
                7'h6f};
      18: return 32'hFFFF_FFFF;
      default: return {25'($urandom), 7'h5b};
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    funit_ZCNVFlags = 4'b0;
    r_for_pc = 32'd0;
    directed(14, 1'b0);
    directed(10, 1'b1);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 64; i++) mem[i] = gen_instr();
      funit_ZCNVFlags = 4'b0;
      do_reset();
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        compare_model();
        funit_ZCNVFlags = 4'($urandom);
        r_for_pc = 32'($urandom_range(0, 255));
        model_step();
      end
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
